bram_arbiter: RTL

- Shares one synchronous single-port block RAM (32-bit, word addressed; en=1 writes and echoes di on do, en=0 reads into do next cycle) between two requesters of the softcore.
- Port A is instruction fetch (read-only). Port B is load/store (read/write with byte strobes).
- The RAM has no byte enables, so partial stores are executed as read-modify-write (RMW) sequences.
- Round-robin arbitration between A and B.

---
 rtl/bram_arbiter_pkg.sv | 21 ++
 rtl/bram_byte_merge.sv | 23 ++
 rtl/bram_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the block-RAM arbiter and its byte-merge helper.
package bram_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RMW  = 1'b1
   } state_e;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

   localparam int unsigned BYTE_W = 8;

   // Strobe width for a data width; data width must be a whole number of bytes.
   function automatic int unsigned strb_width(input int unsigned width);
      return width / BYTE_W;
   endfunction

endpackage

// File: rtl/bram_byte_merge.sv
// Per-byte-lane select between old and new data under a write strobe (purely combinational).
module bram_byte_merge
   import bram_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STRB_W = strb_width(WIDTH)
) (
   input  logic [WIDTH-1:0]  old_i,
   input  logic [WIDTH-1:0]  new_i,
   input  logic [STRB_W-1:0] strb_i,
   output logic [WIDTH-1:0]  merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int unsigned i = 0; i < STRB_W; i++) begin
         if (strb_i[i]) begin
            merged_o[i*BYTE_W +: BYTE_W] = new_i[i*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one write-first single-port block RAM between an
// instruction-fetch port (A, read-only) and a load/store port (B, partial stores via RMW).
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH_LOG = 8,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned STRB_W    = strb_width(WIDTH)
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 a_req,
   input  logic [DEPTH_LOG-1:0] a_addr,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [WIDTH-1:0]     a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [DEPTH_LOG-1:0] b_addr,
   input  logic [WIDTH-1:0]     b_wdata,
   input  logic [STRB_W-1:0]    b_wstrb,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [WIDTH-1:0]     b_rdata,
   output logic                 ram_en,
   output logic [DEPTH_LOG-1:0] ram_addr,
   output logic [WIDTH-1:0]     ram_di,
   input  logic [WIDTH-1:0]     ram_do
);

   state_e           state_q, state_d;
   sel_e             rr_q, rr_d;
   logic             a_rvalid_q, b_rvalid_q;
   logic [WIDTH-1:0] a_rdata_q, b_rdata_q;
   logic [WIDTH-1:0] merged;
   logic             strb_full, strb_none;

   assign strb_full = &b_wstrb;
   assign strb_none = ~|b_wstrb;

   bram_byte_merge #(
      .WIDTH  (WIDTH),
      .STRB_W (STRB_W)
   ) u_merge (
      .old_i    (ram_do),
      .new_i    (b_wdata),
      .strb_i   (b_wstrb),
      .merged_o (merged)
   );

   // Everything is gated by resetb so a reset landing in the RMW cycle issues no write.
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      a_gnt    = 1'b0;
      b_gnt    = 1'b0;
      ram_en   = 1'b0;
      ram_addr = '0;
      ram_di   = b_wdata;
      if (resetb) begin
         case (state_q)
            ST_IDLE: begin
               if (a_req && (!b_req || rr_q == SEL_A)) begin
                  a_gnt    = 1'b1;
                  ram_addr = a_addr;
                  rr_d     = SEL_B;
               end else if (b_req) begin
                  ram_addr = b_addr;
                  if (!b_we || strb_none) begin
                     b_gnt = 1'b1;
                     rr_d  = SEL_A;
                  end else if (strb_full) begin
                     ram_en = 1'b1;
                     b_gnt  = 1'b1;
                     rr_d   = SEL_A;
                  end else begin
                     state_d = ST_RMW;
                  end
               end
            end
            ST_RMW: begin
               ram_en   = 1'b1;
               ram_addr = b_addr;
               ram_di   = merged;
               b_gnt    = 1'b1;
               rr_d     = SEL_A;
               state_d  = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q    <= ST_IDLE;
         rr_q       <= SEL_B;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         a_rvalid_q <= a_gnt;
         b_rvalid_q <= b_gnt && !b_we;
         if (a_rvalid_q) a_rdata_q <= ram_do;
         if (b_rvalid_q) b_rdata_q <= ram_do;
      end
   end

   // RAM output is already registered: present it live during rvalid, then hold the capture.
   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rvalid_q ? ram_do : a_rdata_q;
   assign b_rdata  = b_rvalid_q ? ram_do : b_rdata_q;

   b_stable_until_gnt: assert property (
      @(posedge clk) disable iff (!resetb)
      (b_req && !b_gnt) |=> (b_req && $stable(b_we) && $stable(b_addr)
                             && $stable(b_wdata) && $stable(b_wstrb))
   ) else $error("port B request changed before grant");

endmodule
